glyph_row_shifter: RTL and testbench

- Parametrised successor to the character-ROM byte fetcher in the VGA text path.
- Accepts glyph/row requests over a valid/ready handshake and issues a registered read to the external character ROM, tolerating configurable ROM latency.
- Double-buffers the returned row and serialises it MSB-first, one pixel per pixel strobe, with seamless back-to-back glyphs.
- Sits between the text-cell scanner and the VGA colour mux.

---
 rtl/glyph_row_shifter.sv | 201 ++++++++++++++++++++
 tb/tb_glyph_row_shifter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_row_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : glyph_row_shifter
// Purpose  : Fetches one glyph row from the external character ROM per
//            accepted request, double-buffers it and serialises it MSB-first,
//            one pixel per pix_en strobe, with gap-free back-to-back glyphs.
// Ports    : clock, reset (async, active-low)
//            req_valid/req_ready/req_glyph/req_row  - request handshake
//            req_inv                                - invert row (optional)
//            rom_en/rom_addr/rom_data               - character ROM port
//            pix_en/pix_bit/pix_valid/underrun      - pixel stream
// Options  : define GLYPH_INVERT_EN to add req_inv (bitwise row inversion).
// Revision : 1.0 - initial release
// ============================================================================
module glyph_row_shifter #(
  parameter int PIX_W      = 8,
  parameter int GLYPH_W    = 3,
  parameter int ROW_W      = 4,
  parameter int NUM_GLYPHS = 4,
  parameter int ROM_LAT    = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [GLYPH_W-1:0]       req_glyph,
  input  logic [ROW_W-1:0]         req_row,
`ifdef GLYPH_INVERT_EN
  input  logic                     req_inv,
`endif
  output logic                     rom_en,
  output logic [GLYPH_W+ROW_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]         rom_data,
  input  logic                     pix_en,
  output logic                     pix_bit,
  output logic                     pix_valid,
  output logic                     underrun
);

  localparam int c_LAT_W = $clog2(ROM_LAT + 1);
  localparam int c_BIT_W = $clog2(PIX_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_FULL = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_nextState;
  logic                       w_romEnNext;

  // Held low through reset and set on the first clock after release, so
  // req_ready cannot be seen high while the block is still in reset.
  logic                       r_started;
  logic                       r_romEn;
  logic [GLYPH_W+ROW_W-1:0]   r_romAddr;
  logic [c_LAT_W-1:0]         r_latCnt;
  logic                       r_inv;
  logic [PIX_W-1:0]           r_buf;
  logic [PIX_W-1:0]           r_shreg;
  logic [c_BIT_W-1:0]         r_bitCnt;
  logic                       r_pixValid;
  logic                       r_underrun;

  logic                       w_accept;
  logic                       w_isBlank;
  logic                       w_reqInv;
  logic                       w_capture;
  logic                       w_lastBit;
  logic                       w_take;

`ifdef GLYPH_INVERT_EN
  assign w_reqInv = req_inv;
`else
  assign w_reqInv = 1'b0;
`endif

  // In IDLE the buffer is always empty, so the state alone gates acceptance.
  assign req_ready = r_started & (r_state == ST_IDLE);
  assign w_accept  = req_valid & req_ready;
  assign w_isBlank = !(32'(req_glyph) < NUM_GLYPHS);

  // Counter reaches zero exactly on the edge where the ROM row is valid.
  assign w_capture = (r_state == ST_WAIT) && (r_latCnt == '0);
  assign w_lastBit = (r_bitCnt == c_BIT_W'(1));

  // The shifter takes the buffer when it is idle, or on its final pixel so
  // the next row follows without a gap.
  assign w_take = (r_state == ST_FULL) && (!r_pixValid || (pix_en && w_lastBit));

  // --------------------------------------------------------------------------
  // Fetch FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_romEnNext = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_isBlank) begin
            w_nextState = ST_FULL;
          end else begin
            w_nextState = ST_WAIT;
            w_romEnNext = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (w_capture) begin
          w_nextState = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_take) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // ROM request, latency counter and row buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_started <= 1'b0;
      r_romEn   <= 1'b0;
      r_romAddr <= '0;
      r_latCnt  <= '0;
      r_inv     <= 1'b0;
      r_buf     <= '0;
    end else begin
      r_started <= 1'b1;
      r_romEn   <= w_romEnNext;
      if (w_accept) begin
        r_inv    <= w_reqInv;
        r_latCnt <= c_LAT_W'(ROM_LAT);
        if (w_isBlank) begin
          r_buf <= {PIX_W{w_reqInv}};
        end else begin
          r_romAddr <= {req_glyph, req_row};
        end
      end else if (r_state == ST_WAIT) begin
        if (w_capture) begin
          r_buf <= r_inv ? ~rom_data : rom_data;
        end else begin
          r_latCnt <= r_latCnt - c_LAT_W'(1);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Pixel shifter
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shreg    <= '0;
      r_bitCnt   <= '0;
      r_pixValid <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= pix_en & ~r_pixValid;
      if (w_take) begin
        r_shreg    <= r_buf;
        r_bitCnt   <= c_BIT_W'(PIX_W);
        r_pixValid <= 1'b1;
      end else if (pix_en && r_pixValid) begin
        if (w_lastBit) begin
          r_shreg    <= '0;
          r_bitCnt   <= '0;
          r_pixValid <= 1'b0;
        end else begin
          r_shreg  <= {r_shreg[PIX_W-2:0], 1'b0};
          r_bitCnt <= r_bitCnt - c_BIT_W'(1);
        end
      end
    end
  end

  assign rom_en    = r_romEn;
  assign rom_addr  = r_romAddr;
  assign pix_bit   = r_shreg[PIX_W-1];
  assign pix_valid = r_pixValid;
  assign underrun  = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_glyph_row_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_glyph_row_shifter
// Purpose  : Self-checking bench for glyph_row_shifter. One instance runs with
//            ROM_LAT=1, a second with ROM_LAT=3. Expected pixels are queued
//            when a request is accepted and popped as pixels are consumed.
// Revision : 1.0 - initial release
// ============================================================================
module tb_glyph_row_shifter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
`ifdef GLYPH_INVERT_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  logic       clock;
  logic       reset;
  logic       reqValid, reqReady;
  logic [2:0] reqGlyph;
  logic [3:0] reqRow;
  logic       romEn;
  logic [6:0] romAddr;
  logic [7:0] romData;
  logic       pixEn, pixBit, pixValid, underrun;
`ifdef GLYPH_INVERT_EN
  logic       reqInv;
  logic       reqInv3;
`endif

  logic       reqValid3, reqReady3;
  logic [2:0] reqGlyph3;
  logic [3:0] reqRow3;
  logic       romEn3;
  logic [6:0] romAddr3;
  logic [7:0] romData3;
  logic       pixEn3, pixBit3, pixValid3, underrun3;

  logic [7:0] romMem [0:127];
  logic       sbQ [$];
  int         total = 0;
  int         bad = 0;
  int         romEnSeen = 0;
  int         expRomEn = 0;
  int         pixMode = 0;

  glyph_row_shifter #(.ROM_LAT(LAT_A)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(reqValid), .req_ready(reqReady),
    .req_glyph(reqGlyph), .req_row(reqRow),
`ifdef GLYPH_INVERT_EN
    .req_inv(reqInv),
`endif
    .rom_en(romEn), .rom_addr(romAddr), .rom_data(romData),
    .pix_en(pixEn), .pix_bit(pixBit), .pix_valid(pixValid), .underrun(underrun)
  );

  glyph_row_shifter #(.ROM_LAT(LAT_B)) u_dut3 (
    .clock(clock), .reset(reset),
    .req_valid(reqValid3), .req_ready(reqReady3),
    .req_glyph(reqGlyph3), .req_row(reqRow3),
`ifdef GLYPH_INVERT_EN
    .req_inv(reqInv3),
`endif
    .rom_en(romEn3), .rom_addr(romAddr3), .rom_data(romData3),
    .pix_en(pixEn3), .pix_bit(pixBit3), .pix_valid(pixValid3), .underrun(underrun3)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ROM models: valid data only in the cycle LAT cycles after the rom_en
  // cycle, random garbage at every other time.
  initial begin
    int cd = 0;
    logic [6:0] a = '0;
    romData = '0;
    forever begin
      @(posedge clock);
      if (romEn) begin cd = LAT_A; a = romAddr; end
      else if (cd > 0) cd--;
      #1;
      romData = (cd == 1) ? romMem[a] : 8'($urandom);
    end
  end

  initial begin
    int cd = 0;
    logic [6:0] a = '0;
    romData3 = '0;
    forever begin
      @(posedge clock);
      if (romEn3) begin cd = LAT_B; a = romAddr3; end
      else if (cd > 0) cd--;
      #1;
      romData3 = (cd == 1) ? romMem[a] : 8'($urandom);
    end
  end

  // Pixel strobe: 0 = off, 1 = always on, 2 = random.
  initial begin
    pixEn = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      pixEn = (pixMode == 2) ? 1'($urandom_range(0, 1)) : (pixMode != 0);
    end
  end

  // Scoreboard monitor for the main instance.
  initial begin
    logic e;
    forever begin
      @(negedge clock);
      if (romEn) romEnSeen++;
      if (pixEn && pixValid) begin
        checkVal("pix_pending", {31'd0, sbQ.size() != 0}, 1);
        if (sbQ.size() != 0) begin
          e = sbQ.pop_front();
          checkVal("pix_bit", pixBit, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Must be called just after a negedge.
  task automatic sendReq(input logic [2:0] g, input logic [3:0] r, input logic inv);
    int n = 0;
    logic blank;
    logic [7:0] row;
    blank = (g >= 3'd4);
    row = blank ? 8'h00 : romMem[{g, r}];
    if (INV_EN && inv) row = ~row;
    reqGlyph = g;
    reqRow   = r;
    reqValid = 1'b1;
`ifdef GLYPH_INVERT_EN
    reqInv = inv;
`endif
    while (!reqReady && n < 200) begin @(negedge clock); n++; end
    checkVal("req_accept", {31'd0, reqReady}, 1);
    for (int i = 7; i >= 0; i--) sbQ.push_back(row[i]);
    if (!blank) expRomEn++;
    @(posedge clock);
    #1 reqValid = 1'b0;
    @(negedge clock);
    checkVal("rom_en_pulse", romEn, !blank);
    if (!blank) checkVal("rom_addr", romAddr, {g, r});
    @(negedge clock);
    checkVal("rom_en_single", romEn, 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((sbQ.size() != 0 || pixValid) && n < 500) begin @(negedge clock); n++; end
    checkVal("drain", sbQ.size(), 0);
  endtask

  initial begin
    int n;
    logic [7:0] row3;
    for (int i = 0; i < 128; i++) romMem[i] = 8'h00;
    reset = 1'b1;
    reqValid = 1'b0; reqGlyph = '0; reqRow = '0;
    reqValid3 = 1'b0; reqGlyph3 = '0; reqRow3 = '0; pixEn3 = 1'b0;
`ifdef GLYPH_INVERT_EN
    reqInv = 1'b0; reqInv3 = 1'b0;
`endif
    #1 reset = 1'b0;
    #1;
    checkVal("rst_req_ready", reqReady, 0);
    checkVal("rst_rom_en", romEn, 0);
    checkVal("rst_rom_addr", romAddr, 0);
    checkVal("rst_pix_bit", pixBit, 0);
    checkVal("rst_pix_valid", pixValid, 0);
    checkVal("rst_underrun", underrun, 0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1 checkVal("rel_ready_low", reqReady, 0);
    @(negedge clock);
    checkVal("rel_ready_high", reqReady, 1);

    // Basic fetch and serialisation.
    romMem[7'h13] = 8'hA5;
    romMem[{3'd2, 4'd1}] = 8'hFF;
    romMem[{3'd3, 4'd2}] = 8'h0F;
    romMem[{3'd2, 4'd7}] = 8'h96;
    romMem[{3'd3, 4'd15}] = 8'h5A;
    pixMode = 1;
    sendReq(3'd1, 4'd3, 1'b0);
    drain();

    // Blank glyph.
    sendReq(3'd5, 4'd0, 1'b0);
    drain();

    // Back-to-back rows with no pix_valid gap.
    fork
      begin
        sendReq(3'd2, 4'd1, 1'b0);
        sendReq(3'd3, 4'd2, 1'b0);
      end
      begin
        int m = 0;
        while (!pixValid && m < 50) begin @(negedge clock); m++; end
        checkVal("b2b_start", {31'd0, m < 50}, 1);
        for (int i = 0; i < 16; i++) begin
          checkVal("b2b_valid", pixValid, 1);
          if (i > 0) checkVal("b2b_no_underrun", underrun, 0);
          @(negedge clock);
        end
      end
    join
    drain();

    // Irregular pixel strobe.
    pixMode = 2;
    sendReq(3'd2, 4'd7, 1'b0);
    sendReq(3'd3, 4'd15, 1'b0);
    drain();
    pixMode = 1;

    // Starvation.
    repeat (3) @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      checkVal("starve_underrun", underrun, 1);
      checkVal("starve_valid", pixValid, 0);
      @(negedge clock);
    end

    // ROM_LAT=3 instance: garbage before the valid cycle must never show.
    row3 = 8'h3C;
    romMem[{3'd2, 4'd6}] = row3;
    pixEn3 = 1'b1;
    reqGlyph3 = 3'd2; reqRow3 = 4'd6; reqValid3 = 1'b1;
    n = 0;
    while (!reqReady3 && n < 50) begin @(negedge clock); n++; end
    checkVal("lat3_accept", reqReady3, 1);
    @(posedge clock);
    #1 reqValid3 = 1'b0;
    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        checkVal("lat3_rom_en", romEn3, 1);
        checkVal("lat3_rom_addr", romAddr3, 7'h26);
      end
      if (n == 2) checkVal("lat3_rom_en_single", romEn3, 0);
    end while (!pixValid3 && n < 40);
    checkVal("lat3_cycles", n, LAT_B + 3);
    for (int i = 0; i < 8; i++) begin
      checkVal("lat3_valid", pixValid3, 1);
      checkVal("lat3_bit", pixBit3, row3[7-i]);
      @(negedge clock);
    end
    checkVal("lat3_end", pixValid3, 0);
    pixEn3 = 1'b0;

    // Reset asserted while waiting on the ROM.
    checkVal("rstw_pre_ready", reqReady, 1);
    reqGlyph = 3'd1; reqRow = 4'd3; reqValid = 1'b1;
    @(posedge clock);
    #1 reqValid = 1'b0;
    @(negedge clock);
    checkVal("rstw_rom_en", romEn, 1);
    expRomEn++;
    #2 reset = 1'b0;
    #1;
    checkVal("rstw_req_ready", reqReady, 0);
    checkVal("rstw_rom_en_clr", romEn, 0);
    checkVal("rstw_rom_addr", romAddr, 0);
    checkVal("rstw_pix_bit", pixBit, 0);
    checkVal("rstw_pix_valid", pixValid, 0);
    checkVal("rstw_underrun", underrun, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1 checkVal("rstw_rel_low", reqReady, 0);
    @(negedge clock);
    checkVal("rstw_rel_high", reqReady, 1);
    repeat (6) @(negedge clock);
    checkVal("rstw_discard", pixValid, 0);

`ifdef GLYPH_INVERT_EN
    sendReq(3'd1, 4'd3, 1'b1);
    drain();
    sendReq(3'd6, 4'd0, 1'b1);
    drain();
`endif

    repeat (4) @(negedge clock);
    checkVal("rom_en_count", romEnSeen, expRomEn);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
